// File: rtl/rx_mac_lite_pkg.sv
// Shared definitions for the rx_mac_lite adapters: framer state type and
// word-size constants derived from the Avalon-ST data bus width.
package rx_mac_lite_pkg;

  localparam int AVST_DATA_WIDTH = 512;
  localparam int BYTES           = AVST_DATA_WIDTH / 8;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } frame_state_e;

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at its maximum value instead of wrapping.
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  output logic [15:0] o_cnt
);

  logic [15:0] r_cnt;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/eth_avst_to_mfb_framer.sv
// Converts MAC-side Avalon-ST frames into single-region MFB words, one cycle
// later, tagging undersized/errored frames and counting protocol violations.
module eth_avst_to_mfb_framer
  import rx_mac_lite_pkg::*;
#(
  parameter int DATA_WIDTH    = 512,
  parameter int MIN_FRAME_LEN = 64
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic [DATA_WIDTH-1:0]             IN_AVST_DATA,
  input  logic                              IN_AVST_SOP,
  input  logic                              IN_AVST_EOP,
  input  logic                              IN_AVST_VALID,
  input  logic                              IN_AVST_ERROR,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   IN_AVST_EMPTY,
  output logic [DATA_WIDTH-1:0]             OUT_MFB_DATA,
  output logic                              OUT_MFB_SOF,
  output logic                              OUT_MFB_EOF,
  output logic                              OUT_MFB_SRC_RDY,
  output logic [$clog2(DATA_WIDTH/8)-1:0]   OUT_MFB_EOF_POS,
  output logic                              OUT_MFB_UNDERSIZED,
  output logic                              OUT_MFB_ERROR,
  output logic [15:0]                       OUT_VIOLATION_CNT
);

  localparam int NBYTES = bytes_of(DATA_WIDTH);
  localparam int PW     = $clog2(NBYTES);
  localparam int CW     = $clog2(MIN_FRAME_LEN + 1);
  localparam int SW     = ((CW > PW + 1) ? CW : PW + 1) + 1;

  frame_state_e r_state, w_state_nxt;

  logic [CW-1:0]         r_byte_cnt, w_byte_cnt_nxt;
  logic [SW-1:0]         w_word_bytes;
  logic                  w_src_rdy, w_sof, w_eof, w_undersized, w_error, w_viol;
  logic [PW-1:0]         w_eof_pos;

  logic                  r_src_rdy, r_sof, r_eof, r_undersized, r_error;
  logic [PW-1:0]         r_eof_pos;
  logic [DATA_WIDTH-1:0] r_data;

  // The running length only has to resolve "below MIN_FRAME_LEN or not".
  function automatic logic [CW-1:0] sat_len(input logic [SW-1:0] len);
    return (len >= SW'(MIN_FRAME_LEN)) ? CW'(MIN_FRAME_LEN) : CW'(len);
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_src_rdy      = 1'b0;
    w_sof          = 1'b0;
    w_eof          = 1'b0;
    w_eof_pos      = '0;
    w_error        = 1'b0;
    w_viol         = 1'b0;
    w_word_bytes   = IN_AVST_EOP ? SW'(NBYTES) - SW'(IN_AVST_EMPTY) : SW'(NBYTES);

    if (IN_AVST_VALID) begin
      unique case (r_state)
        ST_IDLE: begin
          if (IN_AVST_SOP) begin
            w_src_rdy      = 1'b1;
            w_sof          = 1'b1;
            w_byte_cnt_nxt = sat_len(w_word_bytes);
            if (IN_AVST_EOP) begin
              w_eof     = 1'b1;
              w_eof_pos = PW'(NBYTES - 1) - IN_AVST_EMPTY;
              w_error   = IN_AVST_ERROR;
            end else begin
              w_state_nxt = ST_IN_FRAME;
            end
          end else begin
            w_viol = 1'b1;
          end
        end
        ST_IN_FRAME: begin
          w_src_rdy = 1'b1;
          if (IN_AVST_SOP) begin
            // A new SOP cuts the current frame short: close it as a full,
            // errored word and drop the SOP itself.
            w_eof          = 1'b1;
            w_eof_pos      = '1;
            w_error        = 1'b1;
            w_byte_cnt_nxt = sat_len(SW'(r_byte_cnt) + SW'(NBYTES));
            w_state_nxt    = ST_IDLE;
            w_viol         = 1'b1;
          end else begin
            w_byte_cnt_nxt = sat_len(SW'(r_byte_cnt) + w_word_bytes);
            if (IN_AVST_EOP) begin
              w_eof       = 1'b1;
              w_eof_pos   = PW'(NBYTES - 1) - IN_AVST_EMPTY;
              w_error     = IN_AVST_ERROR;
              w_state_nxt = ST_IDLE;
            end
          end
        end
      endcase
    end

    w_undersized = w_eof && (w_byte_cnt_nxt < CW'(MIN_FRAME_LEN));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_byte_cnt   <= '0;
      r_src_rdy    <= 1'b0;
      r_sof        <= 1'b0;
      r_eof        <= 1'b0;
      r_eof_pos    <= '0;
      r_undersized <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_src_rdy    <= w_src_rdy;
      r_sof        <= w_sof;
      r_eof        <= w_eof;
      r_eof_pos    <= w_eof_pos;
      r_undersized <= w_undersized;
      r_error      <= w_error;
    end
  end

  // NOTE: the data path carries no reset; it is only meaningful alongside
  // SRC_RDY, and leaving it unreset keeps the wide register bank cheap.
  always_ff @(posedge CLK) begin
    r_data <= IN_AVST_DATA;
  end

  sat_cnt16 u_violation_cnt (
    .clk   (CLK),
    .rst   (RESET),
    .i_inc (w_viol),
    .o_cnt (OUT_VIOLATION_CNT)
  );

  assign OUT_MFB_DATA       = r_data;
  assign OUT_MFB_SOF        = r_sof;
  assign OUT_MFB_EOF        = r_eof;
  assign OUT_MFB_SRC_RDY    = r_src_rdy;
  assign OUT_MFB_EOF_POS    = r_eof_pos;
  assign OUT_MFB_UNDERSIZED = r_undersized;
  assign OUT_MFB_ERROR      = r_error;

endmodule

// File: tb/tb_eth_avst_to_mfb_framer.sv
// Self-checking bench for eth_avst_to_mfb_framer: directed scenarios plus a
// randomized stream checked against a frame-level reference model.
module tb_eth_avst_to_mfb_framer;

  localparam int DW   = 512;
  localparam int NB   = DW / 8;
  localparam int EW   = $clog2(NB);
  localparam int MINL = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] avst_data;
  logic          sop, eop, valid, err;
  logic [EW-1:0] empty;
  logic [DW-1:0] o_data;
  logic          sof, eof, rdy, und, ferr;
  logic [EW-1:0] pos;
  logic [15:0]   cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eth_avst_to_mfb_framer #(.DATA_WIDTH(DW), .MIN_FRAME_LEN(MINL)) dut (
    .CLK                (clk),
    .RESET              (rst),
    .IN_AVST_DATA       (avst_data),
    .IN_AVST_SOP        (sop),
    .IN_AVST_EOP        (eop),
    .IN_AVST_VALID      (valid),
    .IN_AVST_ERROR      (err),
    .IN_AVST_EMPTY      (empty),
    .OUT_MFB_DATA       (o_data),
    .OUT_MFB_SOF        (sof),
    .OUT_MFB_EOF        (eof),
    .OUT_MFB_SRC_RDY    (rdy),
    .OUT_MFB_EOF_POS    (pos),
    .OUT_MFB_UNDERSIZED (und),
    .OUT_MFB_ERROR      (ferr),
    .OUT_VIOLATION_CNT  (cnt)
  );

  // Reference model: frame-level view with an unbounded byte total.
  bit m_in_frame;
  int m_bytes;
  int m_viol;

  typedef struct {
    bit            rdy;
    bit            sof;
    bit            eof;
    int            pos;
    bit            und;
    bit            err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t e;

  task automatic model_reset();
    m_in_frame = 0;
    m_bytes    = 0;
    m_viol     = 0;
  endtask

  task automatic model_violation();
    if (m_viol < 65535) m_viol++;
  endtask

  task automatic model(input bit v, input bit s, input bit p, input bit er,
                       input int emp, input logic [DW-1:0] d);
    e.rdy = 0; e.sof = 0; e.eof = 0; e.pos = 0; e.und = 0; e.err = 0; e.data = d;
    if (!v) return;
    if (!m_in_frame) begin
      if (!s) begin
        model_violation();
        return;
      end
      e.rdy   = 1;
      e.sof   = 1;
      m_bytes = p ? NB - emp : NB;
      if (p) begin
        e.eof = 1; e.pos = NB - 1 - emp; e.err = er; e.und = (m_bytes < MINL);
      end else begin
        m_in_frame = 1;
      end
    end else if (s) begin
      m_bytes   += NB;
      e.rdy      = 1; e.eof = 1; e.pos = NB - 1; e.err = 1; e.und = (m_bytes < MINL);
      m_in_frame = 0;
      model_violation();
    end else begin
      e.rdy    = 1;
      m_bytes += p ? NB - emp : NB;
      if (p) begin
        e.eof = 1; e.pos = NB - 1 - emp; e.err = er; e.und = (m_bytes < MINL);
        m_in_frame = 0;
      end
    end
  endtask

  // Drive one word, advance the model, and return #1 after the capturing edge.
  task automatic step(input bit v, input bit s, input bit p, input bit er, input int emp);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    avst_data = d; valid = v; sop = s; eop = p; err = er; empty = EW'(emp);
    model(v, s, p, er, emp, d);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 0; sop = 0; eop = 0; err = 0; empty = '0; avst_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rdy, sof, eof, pos, und, ferr} !== '0 || cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b sof=%0b eof=%0b pos=%0d und=%0b err=%0b cnt=%0d, want all 0",
               rdy, sof, eof, pos, und, ferr, cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    step(1, 1, 1, 0, 0);
    checks++;
    if (!(rdy === 1 && sof === 1 && eof === 1 && pos === 6'd63 && und === 0 && ferr === 0)) begin
      errors++;
      $display("FAIL single_full: rdy=%0b sof=%0b eof=%0b pos=%0d und=%0b err=%0b, want 1 1 1 63 0 0",
               rdy, sof, eof, pos, und, ferr);
    end
    checks++;
    if (o_data !== e.data) begin
      errors++;
      $display("FAIL single_data: got %h want %h", o_data[63:0], e.data[63:0]);
    end
    step(1, 1, 1, 0, 4);
    checks++;
    if (!(rdy === 1 && sof === 1 && eof === 1 && pos === 6'd59 && und === 1)) begin
      errors++;
      $display("FAIL single_short: rdy=%0b sof=%0b eof=%0b pos=%0d und=%0b, want 1 1 1 59 1",
               rdy, sof, eof, pos, und);
    end
  endtask

  task automatic test_multi_word();
    step(1, 1, 0, 0, 0);
    checks++;
    if (!(rdy === 1 && sof === 1 && eof === 0)) begin
      errors++;
      $display("FAIL multi_w1: rdy=%0b sof=%0b eof=%0b, want 1 1 0", rdy, sof, eof);
    end
    step(1, 0, 0, 0, 0);
    checks++;
    if (!(rdy === 1 && sof === 0 && eof === 0) || o_data !== e.data) begin
      errors++;
      $display("FAIL multi_w2: rdy=%0b sof=%0b eof=%0b data_ok=%0b, want 1 0 0 1",
               rdy, sof, eof, o_data === e.data);
    end
    step(1, 0, 1, 1, 62);
    checks++;
    if (!(rdy === 1 && sof === 0 && eof === 1 && pos === 6'd1 && und === 0 && ferr === 1)) begin
      errors++;
      $display("FAIL multi_w3: rdy=%0b sof=%0b eof=%0b pos=%0d und=%0b err=%0b, want 1 0 1 1 0 1",
               rdy, sof, eof, pos, und, ferr);
    end
  endtask

  task automatic test_idle_violation();
    step(1, 0, 0, 0, 0);
    checks++;
    if (rdy !== 1'b0 || cnt !== 16'd1) begin
      errors++;
      $display("FAIL idle_violation: rdy=%0b cnt=%0d, want 0 1", rdy, cnt);
    end
  endtask

  task automatic test_sop_in_frame();
    logic [15:0] c0;
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    c0 = cnt;
    step(1, 1, 0, 0, 0);
    checks++;
    if (!(rdy === 1 && sof === 0 && eof === 1 && pos === 6'd63 && ferr === 1 && und === 0)
        || cnt !== c0 + 16'd1) begin
      errors++;
      $display("FAIL sop_in_frame: rdy=%0b sof=%0b eof=%0b pos=%0d err=%0b und=%0b cnt=%0d, want 1 0 1 63 1 0 %0d",
               rdy, sof, eof, pos, ferr, und, cnt, c0 + 16'd1);
    end
    step(1, 0, 0, 0, 0);
    checks++;
    if (rdy !== 1'b0 || cnt !== c0 + 16'd2) begin
      errors++;
      $display("FAIL sop_in_frame_tail1: rdy=%0b cnt=%0d, want 0 %0d", rdy, cnt, c0 + 16'd2);
    end
    step(1, 0, 1, 0, 5);
    checks++;
    if (rdy !== 1'b0 || cnt !== c0 + 16'd3) begin
      errors++;
      $display("FAIL sop_in_frame_tail2: rdy=%0b cnt=%0d, want 0 %0d", rdy, cnt, c0 + 16'd3);
    end
  endtask

  task automatic test_reset_mid_frame();
    step(1, 1, 0, 0, 0);
    valid = 0;
    rst   = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({rdy, sof, eof, pos, und, ferr} !== '0 || cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_async: rdy=%0b sof=%0b eof=%0b pos=%0d cnt=%0d, want all 0",
               rdy, sof, eof, pos, cnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({rdy, sof, eof, pos, und, ferr} !== '0) begin
      errors++;
      $display("FAIL reset_held: rdy=%0b sof=%0b eof=%0b, want 0 0 0", rdy, sof, eof);
    end
    rst = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 10);
    checks++;
    if (rdy !== 1'b0 || cnt !== 16'd2) begin
      errors++;
      $display("FAIL reset_discard: rdy=%0b cnt=%0d, want 0 2", rdy, cnt);
    end
    step(1, 1, 0, 0, 0);
    checks++;
    if (!(rdy === 1 && sof === 1 && eof === 0) || o_data !== e.data) begin
      errors++;
      $display("FAIL reset_next_sof: rdy=%0b sof=%0b eof=%0b, want 1 1 0", rdy, sof, eof);
    end
    step(1, 0, 1, 1, 3);
    checks++;
    if (!(rdy === 1 && eof === 1 && pos === 6'd60 && und === 0 && ferr === 1) || o_data !== e.data) begin
      errors++;
      $display("FAIL reset_next_eof: rdy=%0b eof=%0b pos=%0d und=%0b err=%0b, want 1 1 60 0 1",
               rdy, eof, pos, und, ferr);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit v, s, p, er;
      int emp;
      v   = ($urandom % 4) != 0;
      s   = m_in_frame ? (($urandom % 10) == 0) : (($urandom % 8) != 0);
      p   = ($urandom % 3) == 0;
      er  = ($urandom % 2) == 1;
      emp = int'($urandom % NB);
      step(v, s, p, er, emp);
      checks++;
      if ({rdy, sof, eof} !== {e.rdy, e.sof, e.eof}) begin
        errors++;
        $display("FAIL rand_flags[%0d]: rdy/sof/eof=%b want %b", n, {rdy, sof, eof}, {e.rdy, e.sof, e.eof});
      end
      if (e.eof) begin
        checks++;
        if (pos !== EW'(e.pos) || und !== e.und || ferr !== e.err) begin
          errors++;
          $display("FAIL rand_eof_meta[%0d]: pos=%0d und=%0b err=%0b want %0d %0b %0b",
                   n, pos, und, ferr, e.pos, e.und, e.err);
        end
      end
      if (e.rdy) begin
        checks++;
        if (o_data !== e.data) begin
          errors++;
          $display("FAIL rand_data[%0d]: got %h want %h", n, o_data[63:0], e.data[63:0]);
        end
      end
      checks++;
      if (cnt !== 16'(m_viol)) begin
        errors++;
        $display("FAIL rand_viol_cnt[%0d]: got %0d want %0d", n, cnt, m_viol);
      end
    end
  endtask

  task automatic test_saturation();
    valid = 0;
    rst   = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 65540; i++) begin
      step(1, 0, 0, 0, 0);
      if (i == 65534) begin
        checks++;
        if (cnt !== 16'd65534) begin
          errors++;
          $display("FAIL sat_before: cnt=%0d want 65534", cnt);
        end
      end
      if (i == 65535) begin
        checks++;
        if (cnt !== 16'd65535) begin
          errors++;
          $display("FAIL sat_reach: cnt=%0d want 65535", cnt);
        end
      end
    end
    checks++;
    if (cnt !== 16'd65535 || cnt !== 16'(m_viol) || rdy !== 1'b0) begin
      errors++;
      $display("FAIL sat_hold: cnt=%0d rdy=%0b want 65535 0", cnt, rdy);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_multi_word();
    test_idle_violation();
    test_sop_in_frame();
    test_reset_mid_frame();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_avst_to_mfb_framer.md
ETH_AVST_TO_MFB_FRAMER -- requirements
Module: eth_avst_to_mfb_framer

Interface
REQ-001 SHALL have generic DATA_WIDTH, default 512, meaning data bus width in bits (power of two, >= 64).
REQ-002 SHALL have generic MIN_FRAME_LEN, default 64, meaning the smallest frame length in bytes (FCS included) that is not undersized.
REQ-003 SHALL have port CLK  in  1  single clock for all logic.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port IN_AVST_DATA  in  DATA_WIDTH  Avalon-ST frame data, byte 0 in bits 7:0.
REQ-006 SHALL have ports IN_AVST_SOP / IN_AVST_EOP / IN_AVST_VALID / IN_AVST_ERROR  in  1 each  start, end, word valid, MAC error (meaningful on EOP word).
REQ-007 SHALL have port IN_AVST_EMPTY  in  log2(DATA_WIDTH/8)  unused bytes at the top of the EOP word.
REQ-008 SHALL have port OUT_MFB_DATA  out  DATA_WIDTH  registered data, single MFB region.
REQ-009 SHALL have ports OUT_MFB_SOF / OUT_MFB_EOF / OUT_MFB_SRC_RDY  out  1 each  MFB framing and valid.
REQ-010 SHALL have port OUT_MFB_EOF_POS  out  log2(DATA_WIDTH/8)  index of last valid byte.
REQ-011 SHALL have ports OUT_MFB_UNDERSIZED / OUT_MFB_ERROR  out  1 each  frame metadata, valid only with EOF.
REQ-012 SHALL have port OUT_VIOLATION_CNT  out  16  saturating count of AVST protocol violations.
REQ-013 SHALL have no destination-ready input; the MAC side never stalls and the block never drops a legal word.

Function
REQ-014 SHALL register all MFB outputs with exactly one cycle latency from the accepted AVST word.
REQ-015 SHALL run FSM states IDLE and IN_FRAME; IDLE->IN_FRAME on VALID&SOP&!EOP; IN_FRAME->IDLE on VALID&EOP; IDLE stays on VALID&SOP&EOP.
REQ-016 SHALL drive OUT_MFB_SRC_RDY=0 in every cycle whose input word is not VALID or is discarded.
REQ-017 SHALL set OUT_MFB_EOF_POS = DATA_WIDTH/8-1-EMPTY on an EOP word, and all-ones on a forced EOF.
REQ-018 SHALL accumulate frame bytes from SOP onward (DATA_WIDTH/8 per non-EOP word, DATA_WIDTH/8-EMPTY on EOP), saturating at MIN_FRAME_LEN.
REQ-019 SHALL assert OUT_MFB_UNDERSIZED with EOF iff the final byte count < MIN_FRAME_LEN.
REQ-020 SHALL pass IN_AVST_ERROR of the EOP word to OUT_MFB_ERROR.
REQ-021 SHALL, in IDLE, discard a VALID word without SOP and increment OUT_VIOLATION_CNT.
REQ-022 SHALL, in IN_FRAME, treat a VALID word with SOP as the last word of the current frame: output EOF=1, SOF=0, EOF_POS all-ones, ERROR=1, UNDERSIZED per REQ-019, go to IDLE, increment OUT_VIOLATION_CNT; the word's SOP is ignored.
REQ-023 SHALL hold OUT_VIOLATION_CNT at 65535 once reached.

Reset
REQ-024 SHALL, while RESET=1, force SRC_RDY, SOF, EOF, UNDERSIZED, ERROR to 0, EOF_POS and byte counter to 0, OUT_VIOLATION_CNT to 0, FSM to IDLE.
REQ-025 SHALL, after reset mid-frame, discard remaining words of that frame per REQ-021 (each counted).
REQ-026 SHALL leave OUT_MFB_DATA unreset.

Structure
REQ-027 SHALL place the FSM state type and the constant BYTES = DATA_WIDTH/8 in the shared rx_mac_lite adapter package.
REQ-028 SHALL instantiate one sub-module, sat_cnt16, for the saturating violation counter; all else inline.

Verification (DATA_WIDTH=512, MIN_FRAME_LEN=64)
REQ-029 SHALL test: single word SOP=EOP=1, EMPTY=0 -> next cycle SOF=EOF=1, EOF_POS=63, UNDERSIZED=0; then SOP=EOP=1, EMPTY=4 -> EOF_POS=59, UNDERSIZED=1.
REQ-030 SHALL test: 130-byte frame over 3 words, last EMPTY=62, ERROR=1 on EOP -> SOF on word 1, EOF on word 3 with EOF_POS=1, UNDERSIZED=0, ERROR=1.
REQ-031 SHALL test: VALID word without SOP in IDLE -> SRC_RDY=0 that cycle, OUT_VIOLATION_CNT 0->1.
REQ-032 SHALL test: SOP word arriving in IN_FRAME -> that output has EOF=1, SOF=0, EOF_POS=63, ERROR=1, counter +1; following non-SOP words discarded and counted.
REQ-033 SHALL test: RESET pulse after word 1 of a 3-word frame -> outputs 0 during reset, words 2-3 discarded, counter=2, next legal frame passes unchanged.
REQ-034 SHALL test: 65540 violations -> OUT_VIOLATION_CNT stays 65535.
